// File: rtl/safety_island_pkg.sv
`default_nettype none
// ============================================================================
// Module      : safety_island_pkg
// Description : Shared constants and types for the safety timer array:
//               register offsets, CTRL/STATUS bit positions, timer mode enum.
// Revision    : 1.0 - initial release
// ============================================================================
package safety_island_pkg;

    // Default channel count and the matching interrupt vector width
    localparam int unsigned NumTimersDefault   = 2;
    localparam int unsigned NumTimerInterrupts = 2 * NumTimersDefault;

    // Per-channel register offsets inside a 0x10 window
    localparam logic [3:0] c_reg_ctrl_off   = 4'h0;
    localparam logic [3:0] c_reg_cnt_off    = 4'h4;
    localparam logic [3:0] c_reg_cmp_off    = 4'h8;
    localparam logic [3:0] c_reg_status_off = 4'hC;

    // CTRL bit positions
    localparam int unsigned c_ctrl_enable_bit   = 0;
    localparam int unsigned c_ctrl_mode_bit     = 1;
    localparam int unsigned c_ctrl_cmp_ie_bit   = 2;
    localparam int unsigned c_ctrl_ovf_ie_bit   = 3;
    localparam int unsigned c_ctrl_prescale_lsb = 8;
    localparam int unsigned c_ctrl_prescale_msb = 15;

    // STATUS bit positions
    localparam int unsigned c_status_cmp_pend_bit = 0;
    localparam int unsigned c_status_ovf_pend_bit = 1;

    typedef enum logic {
        Periodic = 1'b0,
        OneShot  = 1'b1
    } timer_mode_e;

endpackage : safety_island_pkg
`default_nettype wire

// File: rtl/safety_timer_channel.sv
`default_nettype none
// ============================================================================
// Module      : safety_timer_channel
// Description : One timer channel: CTRL/CNT/CMP/STATUS state, tick
//               generation, compare/overflow pending flags and IRQs.
//               Optional prescaler enabled by SAFETY_TIMER_PRESCALER_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module safety_timer_channel #(
    parameter int unsigned CntWidth = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_halt,
    input  logic        i_ctrl_we,
    input  logic        i_cnt_we,
    input  logic        i_cmp_we,
    input  logic        i_status_we,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_ctrl,
    output logic [31:0] o_cnt,
    output logic [31:0] o_cmp,
    output logic [31:0] o_status,
    output logic [1:0]  o_irq
);
    import safety_island_pkg::*;

    localparam logic [CntWidth-1:0] c_cnt_max = '1;

    logic                r_enable;
    timer_mode_e         r_mode;
    logic                r_cmp_ie;
    logic                r_ovf_ie;
    logic [CntWidth-1:0] r_cnt;
    logic [CntWidth-1:0] r_cmp;
    logic                r_cmp_pend;
    logic                r_ovf_pend;

    logic                w_tick;
    logic                w_hw_tick;
    logic                w_match;
    logic                w_at_max;
    logic                w_set_cmp;
    logic                w_set_ovf;
    logic [7:0]          w_prescale_rd;
    logic                w_unused_wdata;

    // Not every write-data bit lands in a register for every CntWidth
    assign w_unused_wdata = ^i_wdata;

`ifdef SAFETY_TIMER_PRESCALER_EN
    logic [7:0] r_prescale;
    logic [7:0] r_ps_cnt;
    logic       w_ps_run;
    logic       w_en_rise;

    assign w_ps_run  = r_enable & ~i_halt;
    assign w_tick    = w_ps_run & (r_ps_cnt == r_prescale);
    assign w_en_rise = i_ctrl_we & i_wdata[c_ctrl_enable_bit] & ~r_enable;
    assign w_prescale_rd = r_prescale;

    // Prescale divider: restarts on enable rising so the first tick is prescale+1 cycles out
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_prescale <= 8'h00;
            r_ps_cnt   <= 8'h00;
        end else begin
            if (i_ctrl_we) begin
                r_prescale <= i_wdata[c_ctrl_prescale_msb:c_ctrl_prescale_lsb];
            end
            if (w_en_rise || w_tick) begin
                r_ps_cnt <= 8'h00;
            end else if (w_ps_run) begin
                r_ps_cnt <= r_ps_cnt + 8'h01;
            end
        end
    end
`else
    assign w_tick        = r_enable & ~i_halt;
    assign w_prescale_rd = 8'h00;
`endif

    // A software CNT write in the same cycle cancels all effects of the tick
    assign w_hw_tick = w_tick & ~i_cnt_we;
    assign w_match   = (r_cnt == r_cmp);
    assign w_at_max  = (r_cnt == c_cnt_max);
    assign w_set_cmp = w_hw_tick & w_match;
    assign w_set_ovf = w_hw_tick & w_at_max & ~w_match;

    // Control fields; one-shot match self-disables unless software writes CTRL that cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_enable <= 1'b0;
            r_mode   <= Periodic;
            r_cmp_ie <= 1'b0;
            r_ovf_ie <= 1'b0;
        end else if (i_ctrl_we) begin
            r_enable <= i_wdata[c_ctrl_enable_bit];
            r_mode   <= timer_mode_e'(i_wdata[c_ctrl_mode_bit]);
            r_cmp_ie <= i_wdata[c_ctrl_cmp_ie_bit];
            r_ovf_ie <= i_wdata[c_ctrl_ovf_ie_bit];
        end else if (w_set_cmp && (r_mode == OneShot)) begin
            r_enable <= 1'b0;
        end
    end

    // Counter and compare value; software write takes priority over a tick
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
            r_cmp <= '0;
        end else begin
            if (i_cnt_we) begin
                r_cnt <= i_wdata[CntWidth-1:0];
            end else if (w_hw_tick) begin
                r_cnt <= (w_match || w_at_max) ? '0 : r_cnt + 1'b1;
            end
            if (i_cmp_we) begin
                r_cmp <= i_wdata[CntWidth-1:0];
            end
        end
    end

    // Pending flags: hardware set beats a simultaneous write-1-to-clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cmp_pend <= 1'b0;
            r_ovf_pend <= 1'b0;
        end else begin
            r_cmp_pend <= w_set_cmp |
                          (r_cmp_pend & ~(i_status_we & i_wdata[c_status_cmp_pend_bit]));
            r_ovf_pend <= w_set_ovf |
                          (r_ovf_pend & ~(i_status_we & i_wdata[c_status_ovf_pend_bit]));
        end
    end

    assign o_ctrl   = {16'h0000, w_prescale_rd, 4'h0, r_ovf_ie, r_cmp_ie, r_mode, r_enable};
    assign o_cnt    = 32'(r_cnt);
    assign o_cmp    = 32'(r_cmp);
    assign o_status = {30'h0, r_ovf_pend, r_cmp_pend};
    assign o_irq    = {r_ovf_pend & r_ovf_ie, r_cmp_pend & r_cmp_ie};

endmodule : safety_timer_channel
`default_nettype wire

// File: rtl/safety_timer_array.sv
`default_nettype none
// ============================================================================
// Module      : safety_timer_array
// Description : Array of NumTimers safety timer channels behind a simple
//               req/gnt/rvalid register port. Address decode, error
//               detection and the one-cycle response live here.
//               Optional macro: SAFETY_TIMER_PRESCALER_EN (per-channel
//               8-bit prescaler in CTRL[15:8]).
// Revision    : 1.0 - initial release
// ============================================================================
module safety_timer_array #(
    parameter int unsigned NumTimers = 2,
    parameter int unsigned CntWidth  = 32,
    parameter int unsigned AddrWidth = 12
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   reg_req_i,
    input  logic                   reg_we_i,
    input  logic [AddrWidth-1:0]   reg_addr_i,
    input  logic [31:0]            reg_wdata_i,
    output logic                   reg_gnt_o,
    output logic                   reg_rvalid_o,
    output logic [31:0]            reg_rdata_o,
    output logic                   reg_err_o,
    input  logic                   halt_i,
    output logic [2*NumTimers-1:0] irq_o
);
    import safety_island_pkg::*;

    localparam int unsigned c_sel_w   = AddrWidth - 4;
    localparam logic [31:0] c_range   = 32'(NumTimers * 16);

    logic               w_aligned;
    logic               w_in_range;
    logic               w_acc_ok;
    logic [c_sel_w-1:0] w_chan_sel;
    logic [3:0]         w_offset;
    logic [31:0]        w_rd_mux;

    logic [31:0]        w_ctrl_rd   [NumTimers];
    logic [31:0]        w_cnt_rd    [NumTimers];
    logic [31:0]        w_cmp_rd    [NumTimers];
    logic [31:0]        w_status_rd [NumTimers];

    logic               r_rvalid;
    logic [31:0]        r_rdata;
    logic               r_err;

    assign reg_gnt_o  = reg_req_i;
    assign w_aligned  = (reg_addr_i[1:0] == 2'b00);
    assign w_in_range = (32'(reg_addr_i) < c_range);
    assign w_acc_ok   = reg_req_i & w_aligned & w_in_range;
    assign w_chan_sel = reg_addr_i[AddrWidth-1:4];
    assign w_offset   = reg_addr_i[3:0];

    for (genvar gi = 0; gi < NumTimers; gi++) begin : g_chan
        logic w_wr_sel;

        assign w_wr_sel = w_acc_ok & reg_we_i & (w_chan_sel == c_sel_w'(gi));

        safety_timer_channel #(
            .CntWidth (CntWidth)
        ) u_chan (
            .clk         (clk_i),
            .rst         (rst_i),
            .i_halt      (halt_i),
            .i_ctrl_we   (w_wr_sel & (w_offset == c_reg_ctrl_off)),
            .i_cnt_we    (w_wr_sel & (w_offset == c_reg_cnt_off)),
            .i_cmp_we    (w_wr_sel & (w_offset == c_reg_cmp_off)),
            .i_status_we (w_wr_sel & (w_offset == c_reg_status_off)),
            .i_wdata     (reg_wdata_i),
            .o_ctrl      (w_ctrl_rd[gi]),
            .o_cnt       (w_cnt_rd[gi]),
            .o_cmp       (w_cmp_rd[gi]),
            .o_status    (w_status_rd[gi]),
            .o_irq       (irq_o[2*gi +: 2])
        );
    end

    // Read mux over the addressed channel register
    always_comb begin
        w_rd_mux = 32'h0;
        for (int i = 0; i < NumTimers; i++) begin
            if (w_chan_sel == c_sel_w'(i)) begin
                case (w_offset)
                    c_reg_ctrl_off:   w_rd_mux = w_ctrl_rd[i];
                    c_reg_cnt_off:    w_rd_mux = w_cnt_rd[i];
                    c_reg_cmp_off:    w_rd_mux = w_cmp_rd[i];
                    c_reg_status_off: w_rd_mux = w_status_rd[i];
                    default:          w_rd_mux = 32'h0;
                endcase
            end
        end
    end

    // Single-cycle response; reset drops any response in flight
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_rvalid <= 1'b0;
            r_rdata  <= 32'h0;
            r_err    <= 1'b0;
        end else begin
            r_rvalid <= reg_req_i;
            r_err    <= reg_req_i & ~(w_aligned & w_in_range);
            r_rdata  <= (w_acc_ok && !reg_we_i) ? w_rd_mux : 32'h0;
        end
    end

    assign reg_rvalid_o = r_rvalid;
    assign reg_rdata_o  = r_rdata;
    assign reg_err_o    = r_err;

endmodule : safety_timer_array
`default_nettype wire
